// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter that shares one pipelined fpmul between NREQ requesters
// and returns each product to the requester that issued it.
module fpmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3,
    parameter int IDXW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_c,
    input  logic              mul_flag,
    output logic [NREQ-1:0]   resp_valid,
    output logic [31:0]       resp_c,
    output logic              resp_flag,
    output logic              idle
);

    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] gnt_idx;
    logic            found;
    logic            accept;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;

    // Entry 0 travels alongside the mul_a/mul_b register, so entry MUL_LAT
    // is the one lined up with mul_c/mul_flag.
    logic [MUL_LAT:0] tag_vld;
    logic [IDXW-1:0]  tag_idx [0:MUL_LAT];

    always_comb begin
        int unsigned     pos;
        logic [IDXW-1:0] cand;
        found   = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            cand = IDXW'(pos);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign accept    = found & ~hold & ~rst;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDXW'(k) == gnt_idx) begin
                sel_a = req_a[k*32 +: 32];
                sel_b = req_b[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            if (gnt_idx == IDXW'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[MUL_LAT-1:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        tag_idx[0] <= gnt_idx;
        for (int unsigned k = 1; k <= MUL_LAT; k++) begin
            tag_idx[k] <= tag_idx[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_c     <= '0;
            resp_flag  <= 1'b0;
        end else if (tag_vld[MUL_LAT]) begin
            resp_valid <= NREQ'(1) << tag_idx[MUL_LAT];
            resp_c     <= mul_c;
            resp_flag  <= mul_flag;
        end else begin
            resp_valid <= '0;
        end
    end

    assign idle = ~(|tag_vld) & ~(|resp_valid);

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a 3-cycle behavioural fpmul attached.
module tb_fpmul_arbiter;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_c;
    logic              mul_flag;
    logic [NREQ-1:0]   resp_valid;
    logic [31:0]       resp_c;
    logic              resp_flag;
    logic              idle;

    int n_chk;
    int n_err;

    logic [31:0] ops_a [0:3];
    logic [31:0] ops_b [0:3];
    logic [31:0] exp_c [0:3];

    fpmul_arbiter #(.NREQ(4), .MUL_LAT(3), .IDXW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .mul_flag   (mul_flag),
        .resp_valid (resp_valid),
        .resp_c     (resp_c),
        .resp_flag  (resp_flag),
        .idle       (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural fpmul: truncating multiply of normal numbers, 3 edges deep.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic [22:0] m;
        logic        s;
        int          e;
        s    = a[31] ^ b[31];
        prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e    = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            m = prod[46:24];
            e = e + 1;
        end else begin
            m = prod[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b1, s, 31'h0};
        return {1'b0, s, e[7:0], m};
    endfunction

    logic [31:0] pa [0:2];
    logic [31:0] pb [0:2];

    always_ff @(posedge clk) begin
        pa[0] <= mul_a;
        pb[0] <= mul_b;
        pa[1] <= pa[0];
        pb[1] <= pb[0];
        pa[2] <= pa[1];
        pb[2] <= pb[1];
    end

    always_comb begin
        logic [32:0] r;
        r        = fmul(pa[2], pb[2]);
        mul_flag = r[32];
        mul_c    = r[31:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        ops_a[0] = 32'h40000000; ops_b[0] = 32'h40400000; exp_c[0] = 32'h40C00000; // 2*3
        ops_a[1] = 32'h3FC00000; ops_b[1] = 32'h40000000; exp_c[1] = 32'h40400000; // 1.5*2
        ops_a[2] = 32'h40800000; ops_b[2] = 32'h3F000000; exp_c[2] = 32'h40000000; // 4*0.5
        ops_a[3] = 32'h40400000; ops_b[3] = 32'h40400000; exp_c[3] = 32'h41100000; // 3*3
        for (int i = 0; i < NREQ; i++) put_ops(i, ops_a[i], ops_b[i]);

        // Reset, with requests pending to show req_ready stays low.
        rst = 1'b1;
        hold = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_mul_a", mul_a, 32'h0);
        check("rst_mul_b", mul_b, 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_c", resp_c, 32'h0);
        check("rst_idle", 32'(idle), 32'h1);

        // Single request on an idle system.
        rst = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check("single_mul_a", mul_a, 32'h40000000);
        check("single_mul_b", mul_b, 32'h40400000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                check("single_early", 32'(resp_valid), 32'h0);
            end else begin
                check("single_resp_valid", 32'(resp_valid), 32'h1);
                check("single_resp_c", resp_c, 32'h40C00000);
                check("single_busy", 32'(idle), 32'h0);
            end
        end
        tick();
        check("single_idle", 32'(idle), 32'h1);
        check("single_pulse", 32'(resp_valid), 32'h0);
        check("single_hold_c", resp_c, 32'h40C00000);

        // All four requesting continuously from ptr=0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c <= 12; c++) begin
            #1;
            if (c < 8) check("rr_ready", 32'(req_ready), 32'h1 << (c % 4));
            else       check("rr_ready_off", 32'(req_ready), 32'h0);
            tick();
            if (c == 7) req_valid = 4'b0000;
            if (c >= 4) begin
                if (c - 4 < 8) begin
                    check("rr_resp_valid", 32'(resp_valid), 32'h1 << ((c - 4) % 4));
                    check("rr_resp_c", resp_c, exp_c[(c - 4) % 4]);
                end else begin
                    check("rr_resp_end", 32'(resp_valid), 32'h0);
                end
            end
        end

        // Move ptr to 2, then requesters 1 and 3 alternate.
        req_valid = 4'b0010;
        #1;
        check("r13_setup_ready", 32'(req_ready), 32'h2);
        tick();
        check("r13_setup_ptr", 32'(dut.ptr), 32'd2);
        req_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("r13_ready", 32'(req_ready), (j % 2 == 0) ? 32'h8 : 32'h2);
            tick();
            check("r13_ptr", 32'(dut.ptr), (j % 2 == 0) ? 32'd0 : 32'd2);
        end
        req_valid = 4'b0000;
        for (int j = 0; j < 6; j++) tick();
        check("r13_idle", 32'(idle), 32'h1);

        // Hold while all request; an op already in flight must still return.
        req_valid = 4'b1111;
        #1;
        check("hold_pre_ready", 32'(req_ready), 32'h4);
        tick();
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("hold_ready", 32'(req_ready), 32'h0);
            tick();
            check("hold_resp_valid", 32'(resp_valid), (i == 4) ? 32'h4 : 32'h0);
            if (i == 4) check("hold_resp_c", resp_c, exp_c[2]);
        end
        check("hold_idle", 32'(idle), 32'h1);
        hold = 1'b0;
        #1;
        check("hold_release_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        for (int j = 0; j < 6; j++) tick();

        // Overflow from requester 2.
        put_ops(2, 32'h7F000000, 32'h7F000000);
        req_valid = 4'b0100;
        #1;
        check("ovf_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        for (int j = 0; j < 3; j++) tick();
        tick();
        check("ovf_resp_valid", 32'(resp_valid), 32'h4);
        check("ovf_resp_flag", 32'(resp_flag), 32'h1);
        check("ovf_resp_c", resp_c, 32'h7F800000);
        tick();
        check("ovf_pulse", 32'(resp_valid), 32'h0);
        check("ovf_flag_hold", 32'(resp_flag), 32'h1);
        put_ops(2, ops_a[2], ops_b[2]);

        // Two accepts, then reset: neither may ever respond.
        req_valid = 4'b0011;
        #1;
        check("mid_ready0", 32'(req_ready), 32'h1);
        tick();
        #1;
        check("mid_ready1", 32'(req_ready), 32'h2);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        check("mid_mul_a", mul_a, 32'h0);
        check("mid_mul_b", mul_b, 32'h0);
        check("mid_resp_c", resp_c, 32'h0);
        check("mid_resp_flag", 32'(resp_flag), 32'h0);
        check("mid_ptr", 32'(dut.ptr), 32'd0);
        check("mid_idle", 32'(idle), 32'h1);
        for (int j = 0; j < 8; j++) begin
            check("mid_no_resp", 32'(resp_valid), 32'h0);
            tick();
        end
        check("mid_final_idle", 32'(idle), 32'h1);
        check("mid_final_c", resp_c, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
